de_multiplexer: RTL and testbench



---
 rtl/de_multiplexer_pkg.sv | 9 +
 rtl/de_multiplexer_mux2.sv | 17 +
 rtl/de_multiplexer.sv | 40 ++++
 tb/tb_de_multiplexer.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/de_multiplexer_pkg.sv
// Shared constants for the registered 2:1 data selector.
// Holds the default bus width and the meaning of each Select level.
package de_multiplexer_pkg;

    localparam int   DEMUX_WIDTH_DEF = 2;
    localparam logic SEL_A           = 1'b0;
    localparam logic SEL_B           = 1'b1;

endpackage : de_multiplexer_pkg

// File: rtl/de_multiplexer_mux2.sv
// Purely combinational WIDTH-bit 2:1 select.
// The wrapping top module registers its output.
module de_multiplexer_mux2
    import de_multiplexer_pkg::*;
#(
    parameter int WIDTH = DEMUX_WIDTH_DEF
) (
    input  logic             i_sel,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_y
);

    // X on i_sel is illegal upstream, so a plain ?: is sufficient here.
    assign o_y = (i_sel == SEL_B) ? i_b : i_a;

endmodule : de_multiplexer_mux2

// File: rtl/de_multiplexer.sv
// Registered 2:1 lane/source switch: Y follows the selected input one clk later.
// An asynchronous, active-high reset forces Y to RST_VAL without waiting for a clock edge.
module de_multiplexer
    import de_multiplexer_pkg::*;
#(
    parameter int               WIDTH   = DEMUX_WIDTH_DEF,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             Select,
    input  logic [WIDTH-1:0] A_in,
    input  logic [WIDTH-1:0] B_in,
    output logic [WIDTH-1:0] Y
);

    logic [WIDTH-1:0] w_sel_data;
    logic [WIDTH-1:0] r_y;

    de_multiplexer_mux2 #(
        .WIDTH (WIDTH)
    ) u_mux2 (
        .i_sel (Select),
        .i_a   (A_in),
        .i_b   (B_in),
        .o_y   (w_sel_data)
    );

    // NOTE: state registers use non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_y <= RST_VAL;
        end else begin
            r_y <= w_sel_data;
        end
    end

    assign Y = r_y;

endmodule : de_multiplexer

// File: tb/tb_de_multiplexer.sv
// Directed self-checking bench for de_multiplexer (WIDTH=2, RST_VAL=0).
module tb_de_multiplexer;

    logic       clk;
    logic       rst;
    logic       Select;
    logic [1:0] A_in;
    logic [1:0] B_in;
    logic [1:0] Y;

    int n_tests = 0;
    int n_fail  = 0;

    de_multiplexer #(
        .WIDTH   (2),
        .RST_VAL (2'b00)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .Select (Select),
        .A_in   (A_in),
        .B_in   (B_in),
        .Y      (Y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge and settle before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [1:0] exp_y;
        logic [1:0] prev_y;
        logic [4:0] combo;

        rst    = 1'b1;
        Select = 1'b0;
        A_in   = 2'b00;
        B_in   = 2'b00;

        // 1. Reset value, then idle zeros for 8 cycles.
        #1;
        check("reset_async_t0", Y, 2'b00);
        tick();
        check("reset_held", Y, 2'b00);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            check($sformatf("idle_zero_%0d", i), Y, 2'b00);
        end

        // 2. Select=0 passes A; B changes are ignored.
        @(negedge clk);
        A_in = 2'b10;
        B_in = 2'b01;
        #1;
        check("no_comb_path_a", Y, 2'b00);
        tick();
        check("sel0_pass_a", Y, 2'b10);
        @(negedge clk);
        B_in = 2'b11;
        tick();
        check("sel0_ignore_b", Y, 2'b10);

        // 3. Select=1 passes B; flipping back restores A on the next edge.
        @(negedge clk);
        Select = 1'b1;
        B_in   = 2'b01;
        #1;
        check("sel_change_not_comb", Y, 2'b10);
        tick();
        check("sel1_pass_b", Y, 2'b01);
        @(negedge clk);
        A_in = 2'b01;
        tick();
        check("sel1_ignore_a", Y, 2'b01);
        @(negedge clk);
        A_in   = 2'b10;
        Select = 1'b0;
        tick();
        check("sel_flip_to_a", Y, 2'b10);

        // 4. Asynchronous reset between edges, then reload of the selected input.
        @(negedge clk);
        Select = 1'b1;
        B_in   = 2'b11;
        tick();
        check("pre_reset_y11", Y, 2'b11);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("reset_mid_cycle", Y, 2'b00);
        tick();
        check("reset_hold_over_edge", Y, 2'b00);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset_release_no_edge", Y, 2'b00);
        tick();
        check("post_reset_load_b", Y, 2'b11);

        // 5. Select and data change in the same cycle.
        @(negedge clk);
        Select = 1'b0;
        A_in   = 2'b00;
        B_in   = 2'b00;
        tick();
        check("simul_setup", Y, 2'b00);
        @(negedge clk);
        Select = 1'b1;
        B_in   = 2'b10;
        tick();
        check("simul_sel_data", Y, 2'b10);

        // 6. Exhaustive sweep against a reference model, checking 1-clk latency.
        prev_y = 2'b10;
        for (int i = 0; i < 32; i++) begin
            combo = 5'(i);
            @(negedge clk);
            Select = combo[4];
            A_in   = combo[3:2];
            B_in   = combo[1:0];
            exp_y  = combo[4] ? combo[1:0] : combo[3:2];
            #1;
            check($sformatf("sweep_hold_%0d", i), Y, prev_y);
            tick();
            check($sformatf("sweep_%0d", i), Y, exp_y);
            prev_y = exp_y;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_de_multiplexer
